sdram_port_arbiter: RTL and testbench

//  Shares one Avalon-MM f2h_sdram port between the frame-write path (HDR capture -> DDR)
//  and the frame-read path (DDR -> video out, 80-beat read bursts). Write bursts are

---
 rtl/sdram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one Avalon-MM SDRAM port between a burst writer and a reader
//
// Ports (clk_100 domain, reset_b asynchronous active low):
//   wr_*  : frame-write master (write, address, burstcount, writedata, urgent -> waitrequest)
//   rd_*  : frame-read master (read, address, burstcount -> waitrequest, readdata, readdatavalid)
//   sd_*  : SDRAM bridge side (read/write strobes, address, burstcount, writedata;
//           waitrequest, readdata, readdatavalid back)
//   rd_pending : read beats accepted by the bridge but not yet returned
//   err_flags  : sticky, [0] zero burstcount granted, [1] readdatavalid with nothing pending
`timescale 1ns/1ps

module sdram_port_arbiter #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 30,
    parameter int MAX_PENDING = 256,
    localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk_100,
    input  logic              reset_b,

    input  logic              wr_write,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [7:0]        wr_burstcount,
    input  logic [DATA_W-1:0] wr_writedata,
    input  logic              wr_urgent,
    output logic              wr_waitrequest,

    input  logic              rd_read,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic [7:0]        rd_burstcount,
    output logic              rd_waitrequest,
    output logic [DATA_W-1:0] rd_readdata,
    output logic              rd_readdatavalid,

    output logic              sd_read,
    output logic              sd_write,
    output logic [ADDR_W-1:0] sd_address,
    output logic [7:0]        sd_burstcount,
    output logic [DATA_W-1:0] sd_writedata,
    input  logic              sd_waitrequest,
    input  logic [DATA_W-1:0] sd_readdata,
    input  logic              sd_readdatavalid,

    output logic [PEND_W-1:0] rd_pending,
    output logic [1:0]        err_flags
);

    localparam int SUM_W = ((PEND_W > 8) ? PEND_W : 8) + 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        beat_cnt;
    logic              last_wr;     // 1: last grant went to the writer
    logic [7:0]        wr_bc_eff, rd_bc_eff;
    logic [SUM_W-1:0]  rd_need;
    logic              rd_ok;
    logic              grant_wr, grant_rd;
    logic              wr_beat, rd_accept;
    logic [PEND_W-1:0] pend_inc, pend_dec;

    // A zero burstcount is carried as a single beat so the FSM cannot stall on it.
    assign wr_bc_eff = (wr_burstcount == 8'd0) ? 8'd1 : wr_burstcount;
    assign rd_bc_eff = (rd_burstcount == 8'd0) ? 8'd1 : rd_burstcount;

    // Only admit a read whose whole burst fits under the outstanding-beat cap.
    assign rd_need = SUM_W'(rd_pending) + SUM_W'(rd_bc_eff);
    assign rd_ok   = rd_read && (rd_need <= SUM_W'(MAX_PENDING));

    // Read return path does not depend on who owns the command channel.
    assign rd_readdata      = sd_readdata;
    assign rd_readdatavalid = sd_readdatavalid;
    assign sd_writedata     = wr_writedata;

    always_comb begin
        state_d        = state_q;
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;
        wr_beat        = 1'b0;
        rd_accept      = 1'b0;
        sd_write       = 1'b0;
        sd_read        = 1'b0;
        sd_address     = '0;
        sd_burstcount  = '0;
        wr_waitrequest = 1'b1;
        rd_waitrequest = 1'b1;
        case (state_q)
            IDLE: begin
                // Urgent writer wins outright; otherwise alternate when both are ready.
                grant_wr = wr_write && (wr_urgent || !rd_ok || !last_wr);
                grant_rd = rd_ok && !grant_wr;
                if (grant_wr)      state_d = WR_BURST;
                else if (grant_rd) state_d = RD_CMD;
            end
            WR_BURST: begin
                sd_write       = wr_write;
                sd_address     = wr_address;
                sd_burstcount  = wr_burstcount;
                wr_waitrequest = sd_waitrequest;
                wr_beat        = wr_write && !sd_waitrequest;
                if (wr_beat && beat_cnt == 8'd1) state_d = IDLE;
            end
            RD_CMD: begin
                sd_read        = rd_read;
                sd_address     = rd_address;
                sd_burstcount  = rd_burstcount;
                rd_waitrequest = sd_waitrequest;
                rd_accept      = rd_read && !sd_waitrequest;
                // A command withdrawn before acceptance just returns the port.
                if (rd_accept || !rd_read) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pend_inc = rd_accept ? PEND_W'(rd_bc_eff) : '0;
    assign pend_dec = (sd_readdatavalid && rd_pending != '0) ? PEND_W'(1) : '0;

    always_ff @(posedge clk_100 or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            beat_cnt   <= '0;
            last_wr    <= 1'b0;
            rd_pending <= '0;
            err_flags  <= '0;
        end else begin
            state_q    <= state_d;
            rd_pending <= rd_pending + pend_inc - pend_dec;
            if (grant_wr) begin
                beat_cnt <= wr_bc_eff;
                last_wr  <= 1'b1;
                if (wr_burstcount == 8'd0) err_flags[0] <= 1'b1;
            end else if (wr_beat) begin
                beat_cnt <= beat_cnt - 8'd1;
            end
            if (grant_rd) begin
                last_wr <= 1'b0;
                if (rd_burstcount == 8'd0) err_flags[0] <= 1'b1;
            end
            if (sd_readdatavalid && rd_pending == '0) err_flags[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
`timescale 1ns/1ps

module tb_sdram_port_arbiter;

    logic        clk_100 = 1'b0;
    logic        reset_b;
    logic        wr_write, wr_urgent, wr_waitrequest;
    logic [29:0] wr_address;
    logic [7:0]  wr_burstcount;
    logic [63:0] wr_writedata;
    logic        rd_read, rd_waitrequest, rd_readdatavalid;
    logic [29:0] rd_address;
    logic [7:0]  rd_burstcount;
    logic [63:0] rd_readdata;
    logic        sd_read, sd_write, sd_waitrequest, sd_readdatavalid;
    logic [29:0] sd_address;
    logic [7:0]  sd_burstcount;
    logic [63:0] sd_writedata, sd_readdata;
    logic [8:0]  rd_pending;
    logic [1:0]  err_flags;

    sdram_port_arbiter dut (
        .clk_100(clk_100), .reset_b(reset_b),
        .wr_write(wr_write), .wr_address(wr_address), .wr_burstcount(wr_burstcount),
        .wr_writedata(wr_writedata), .wr_urgent(wr_urgent), .wr_waitrequest(wr_waitrequest),
        .rd_read(rd_read), .rd_address(rd_address), .rd_burstcount(rd_burstcount),
        .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
        .rd_readdatavalid(rd_readdatavalid),
        .sd_read(sd_read), .sd_write(sd_write), .sd_address(sd_address),
        .sd_burstcount(sd_burstcount), .sd_writedata(sd_writedata),
        .sd_waitrequest(sd_waitrequest), .sd_readdata(sd_readdata),
        .sd_readdatavalid(sd_readdatavalid),
        .rd_pending(rd_pending), .err_flags(err_flags)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [29:0] addr;
        logic [7:0]  bc;
        logic [63:0] data;
    } beat_t;

    beat_t       wq[$];
    beat_t       rq[$];
    logic [63:0] rdq[$];
    int          order_q[$];
    int          gap_q[$];
    int          racc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_left = 0;
    int last_w_end = 0;
    int wr_hi = 0;
    beat_t       m_e;
    logic [63:0] m_d;

    int exp_o3[4] = '{0, 1, 0, 1};
    int exp_o4[4] = '{0, 0, 0, 1};

    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [63:0] wdata(input logic [29:0] a, input int b);
        return {2'b01, a, b[31:0]};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    always @(negedge clk_100) begin
        if (!reset_b) begin
            wr_left = 0;
        end else begin
            if (sd_write) wr_hi++;
            if (rd_readdatavalid) begin
                if (rdq.size() == 0) fail_now("rd_data_unexpected");
                else begin
                    m_d = rdq.pop_front();
                    chk("rd_readdata", rd_readdata, m_d);
                end
            end
            if (sd_write && !sd_waitrequest) begin
                if (wq.size() == 0) fail_now("wr_beat_unexpected");
                else begin
                    m_e = wq.pop_front();
                    chk("wr_address", 64'(sd_address), 64'(m_e.addr));
                    chk("wr_burstcount", 64'(sd_burstcount), 64'(m_e.bc));
                    chk("wr_data", sd_writedata, m_e.data);
                end
                if (wr_left == 0) begin
                    order_q.push_back(0);
                    wr_left = (sd_burstcount == 8'd0) ? 1 : int'(sd_burstcount);
                end
                wr_left--;
                if (wr_left == 0) last_w_end = cyc;
            end
            if (sd_read && !sd_waitrequest) begin
                if (rq.size() == 0) fail_now("rd_cmd_unexpected");
                else begin
                    m_e = rq.pop_front();
                    chk("rd_address", 64'(sd_address), 64'(m_e.addr));
                    chk("rd_burstcount", 64'(sd_burstcount), 64'(m_e.bc));
                end
                order_q.push_back(1);
                gap_q.push_back(cyc - last_w_end);
                racc_q.push_back(int'(rd_pending));
            end
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic do_write(input logic [29:0] a, input int n, input logic urg,
                            input int stop, input logic drop);
        int b = 0;
        int t = 0;
        logic acc;
        beat_t e;
        for (int i = 0; i < stop; i++) begin
            e.addr = a; e.bc = 8'(n); e.data = wdata(a, i);
            wq.push_back(e);
        end
        wr_write = 1'b1; wr_address = a; wr_burstcount = 8'(n);
        wr_urgent = urg; wr_writedata = wdata(a, 0);
        while (b < stop && t < 2000) begin
            @(negedge clk_100);
            acc = !wr_waitrequest;
            tick();
            t++;
            if (acc) begin
                b++;
                wr_writedata = wdata(a, b);
            end
        end
        if (t >= 2000) fail_now("wr_timeout");
        if (drop) begin
            wr_write = 1'b0;
            wr_urgent = 1'b0;
        end
    endtask

    task automatic do_read(input logic [29:0] a, input int n);
        int t = 0;
        logic acc = 1'b0;
        beat_t e;
        e.addr = a; e.bc = 8'(n); e.data = '0;
        rq.push_back(e);
        rd_read = 1'b1; rd_address = a; rd_burstcount = 8'(n);
        while (!acc && t < 2000) begin
            @(negedge clk_100);
            acc = !rd_waitrequest;
            tick();
            t++;
        end
        if (!acc) fail_now("rd_timeout");
        rd_read = 1'b0;
    endtask

    task automatic do_ret(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            sd_readdatavalid = 1'b1;
            sd_readdata = base + 64'(i);
            rdq.push_back(base + 64'(i));
            tick();
        end
        sd_readdatavalid = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_write = 0; wr_urgent = 0; wr_address = '0; wr_burstcount = '0; wr_writedata = '0;
        rd_read = 0; rd_address = '0; rd_burstcount = '0;
        sd_waitrequest = 0; sd_readdatavalid = 0; sd_readdata = '0;
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        idle_inputs();
        tick();
        tick();
        order_q.delete(); gap_q.delete(); racc_q.delete();
        reset_b = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_sd_write", 64'(sd_write), 64'd0);
        chk("rst_sd_read", 64'(sd_read), 64'd0);
        chk("rst_wr_wait", 64'(wr_waitrequest), 64'd1);
        chk("rst_rd_wait", 64'(rd_waitrequest), 64'd1);
        chk("rst_pending", 64'(rd_pending), 64'd0);
        chk("rst_err", 64'(err_flags), 64'd0);
        reset_b = 1'b1;
        tick();

        // Writer alone, 80 beats
        wr_hi = 0;
        do_write(30'h100, 80, 1'b0, 80, 1'b1);
        chk("w80_hi_cycles", 64'(wr_hi), 64'd80);
        chk("w80_wr_wait_after", 64'(wr_waitrequest), 64'd1);
        chk("w80_sd_write_after", 64'(sd_write), 64'd0);

        // Contested, no urgency: W,R,W,R
        do_reset();
        fork
            begin
                do_write(30'h200, 8, 1'b0, 8, 1'b0);
                do_write(30'h300, 8, 1'b0, 8, 1'b1);
            end
            begin
                do_read(30'h400, 80);
                do_read(30'h500, 80);
            end
        join
        chk("alt_order_len", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            chk("alt_order", 64'(order_q[i]), 64'(exp_o3[i]));
        for (int i = 0; i < gap_q.size(); i++)
            chk("alt_rd_gap", 64'(gap_q[i]), 64'd2);
        chk("alt_pending", 64'(rd_pending), 64'd160);

        // Urgent writer holds off the reader for three bursts
        do_reset();
        fork
            begin
                do_write(30'h600, 4, 1'b1, 4, 1'b0);
                do_write(30'h604, 4, 1'b1, 4, 1'b0);
                do_write(30'h608, 4, 1'b1, 4, 1'b1);
            end
            do_read(30'h700, 80);
        join
        chk("urg_order_len", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            chk("urg_order", 64'(order_q[i]), 64'(exp_o4[i]));

        // Outstanding cap
        do_reset();
        do_read(30'h1000, 80);
        do_read(30'h1100, 80);
        do_read(30'h1200, 80);
        chk("cap_pending_240", 64'(rd_pending), 64'd240);
        fork
            do_read(30'h1300, 80);
            begin
                tick(); tick(); tick(); tick();
                do_ret(64, 64'h5000);
            end
        join
        if (racc_q.size() == 4) chk("cap_pending_at_accept", 64'(racc_q[3]), 64'd176);
        else chk("cap_accept_count", 64'(racc_q.size()), 64'd4);
        chk("cap_pending_256", 64'(rd_pending), 64'd256);

        // Accept while a beat returns
        do_reset();
        do_read(30'h2000, 80);
        fork
            begin
                do_read(30'h2100, 80);
                chk("same_cycle_pending", 64'(rd_pending), 64'd158);
            end
            do_ret(6, 64'h6000);
        join
        if (racc_q.size() == 2) chk("same_pending_at_accept", 64'(racc_q[1]), 64'd79);
        else chk("same_accept_count", 64'(racc_q.size()), 64'd2);
        chk("same_pending_end", 64'(rd_pending), 64'd154);

        // Spurious readdatavalid
        do_reset();
        do_ret(1, 64'hDEAD_BEEF_0BAD_F00D);
        chk("spur_err", 64'(err_flags), 64'd2);
        chk("spur_pending", 64'(rd_pending), 64'd0);

        // Zero burstcount write is one beat
        do_write(30'h900, 0, 1'b0, 1, 1'b1);
        chk("bc0_err", 64'(err_flags), 64'd3);
        chk("bc0_wr_wait", 64'(wr_waitrequest), 64'd1);
        do_write(30'hA00, 2, 1'b0, 2, 1'b1);
        chk("bc0_after_wait", 64'(wr_waitrequest), 64'd1);

        // Reset at beat 40 of 80
        do_write(30'hB00, 80, 1'b0, 40, 1'b0);
        reset_b = 1'b0;
        #1;
        chk("midrst_sd_write", 64'(sd_write), 64'd0);
        chk("midrst_wr_wait", 64'(wr_waitrequest), 64'd1);
        chk("midrst_rd_wait", 64'(rd_waitrequest), 64'd1);
        chk("midrst_err", 64'(err_flags), 64'd0);
        wr_write = 1'b0;
        tick();
        reset_b = 1'b1;
        @(negedge clk_100);
        chk("postrst_sd_write", 64'(sd_write), 64'd0);
        chk("postrst_wr_wait", 64'(wr_waitrequest), 64'd1);
        tick();
        do_write(30'hC00, 3, 1'b0, 3, 1'b1);
        chk("postrst_burst_done", 64'(wr_waitrequest), 64'd1);

        tick();
        tick();
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        chk("rdq_empty", 64'(rdq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
